sccb_slave: RTL and testbench

Synthesizable SCCB/I2C responder that emulates the camera's register port on the open-drain SCL/SDA bus driven by `camera_config`. It decodes device-address, sub-address, data-write and data-read phases, holds a 256 x 8 register file, and drives ACK and read data on SDA. It is used as the bus partner in configuration benches and as an FPGA-side loopback target. It reports every accepted write on a one-cycle strobe for checking.

---
 rtl/sccb_slave.sv | 229 ++++++++++++++++++++++
 tb/tb_sccb_slave.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_slave.sv
// SCCB/I2C register-port responder: 256x8 register file, read-only PID bytes, write strobe.
// Latency: bus events act 3 i_clk cycles after the bus edge (2-flop sync + edge stage).
// Backpressure: none; the slave never stretches SCL and only drives ACK/read data on SDA.
module sccb_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h21,
  parameter logic [7:0] PID_H    = 8'h76,
  parameter logic [7:0] PID_L    = 8'h73
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda,
  output logic       o_wr_valid,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DADDR  = 3'd1;
  localparam logic [2:0] ST_DACK   = 3'd2;
  localparam logic [2:0] ST_SADDR  = 3'd3;
  localparam logic [2:0] ST_WDATA  = 3'd4;
  localparam logic [2:0] ST_RDATA  = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_hist_q, sda_hist_q;

  logic [2:0] state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       nack_q, nack_d;
  logic       sda_q, sda_d;
  logic       wr_valid_q, wr_valid_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       busy_q, busy_d;
  logic       mem_we;

  logic [7:0] mem_q [0:255];

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shift_in;
  logic [7:0] rd_byte;

  // Synchronizers and history stage; deliberately not reset so a reset
  // mid-transfer cannot fabricate a START/STOP from a stale history value.
  always_ff @(posedge i_clk) begin
    scl_sync_q <= {scl_sync_q[0], i_scl};
    sda_sync_q <= {sda_sync_q[0], i_sda};
    scl_hist_q <= scl_sync_q[1];
    sda_hist_q <= sda_sync_q[1];
  end

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
  assign shift_in  = {shift_q[6:0], sda_s};

  // Read source: PID bytes shadow the register file at 0x0A/0x0B.
  always_comb begin
    if (ptr_q == 8'h0A)      rd_byte = PID_H;
    else if (ptr_q == 8'h0B) rd_byte = PID_L;
    else                     rd_byte = mem_q[ptr_q];
  end

  // Protocol FSM: bit_cnt 0..7 are data bits, 8 is the ACK-bit low phase, 9 its high phase.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    nack_d     = nack_q;
    sda_d      = sda_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    mem_we     = 1'b0;
    if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      sda_d     = 1'b1;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ST_DADDR;
      bit_cnt_d = 4'd0;
      sda_d     = 1'b1;
    end else begin
      case (state_q)
        ST_DADDR: begin
          if (scl_rise) begin
            shift_d = shift_in;
            if (bit_cnt_q == 4'd7) begin
              if (shift_in[7:1] == DEV_ADDR) begin
                state_d   = ST_DACK;
                rw_d      = shift_in[0];
                busy_d    = 1'b1;
                bit_cnt_d = 4'd8;
              end else begin
                state_d   = ST_IGNORE;
                bit_cnt_d = 4'd0;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ST_DACK: begin
          if (scl_rise && bit_cnt_q == 4'd8) bit_cnt_d = 4'd9;
          if (scl_fall && bit_cnt_q == 4'd8) sda_d = 1'b0;
          if (scl_fall && bit_cnt_q == 4'd9) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              state_d = ST_RDATA;
              sda_d   = rd_byte[7];
            end else begin
              state_d = ST_SADDR;
              sda_d   = 1'b1;
            end
          end
        end
        ST_SADDR, ST_WDATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == ST_SADDR) begin
                ptr_d = shift_in;
              end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = shift_in;
                mem_we     = (ptr_q != 8'h0A) && (ptr_q != 8'h0B);
                ptr_d      = ptr_q + 8'd1;
              end
            end
          end else if (scl_rise && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd9;
          end
          if (scl_fall && bit_cnt_q == 4'd8) sda_d = 1'b0;
          if (scl_fall && bit_cnt_q == 4'd9) begin
            sda_d     = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = ST_WDATA;
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            if (bit_cnt_q < 4'd8) begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd8) begin
              // Pointer advances on the master's ACK so the next byte is ready by the fall.
              bit_cnt_d = 4'd9;
              nack_d    = sda_s;
              if (!sda_s) ptr_d = ptr_q + 8'd1;
            end
          end
          if (scl_fall) begin
            if (bit_cnt_q >= 4'd1 && bit_cnt_q <= 4'd7) begin
              sda_d = rd_byte[3'd7 - bit_cnt_q[2:0]];
            end else if (bit_cnt_q == 4'd8) begin
              sda_d = 1'b1;
            end else if (bit_cnt_q == 4'd9) begin
              bit_cnt_d = 4'd0;
              if (nack_q) begin
                state_d = ST_IGNORE;
                sda_d   = 1'b1;
              end else begin
                sda_d = rd_byte[7];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= 8'h00;
      rw_q       <= 1'b0;
      nack_q     <= 1'b0;
      sda_q      <= 1'b1;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      nack_q     <= nack_d;
      sda_q      <= sda_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
    end
  end

  // Register file write port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && mem_we) mem_q[ptr_q] <= shift_in;
  end

  assign o_sda      = sda_q;
  assign o_wr_valid = wr_valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_sccb_slave.sv
// Bench for sccb_slave: bit-banged SCCB master, wired-AND SDA, byte-level register model.
module tb_sccb_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_sda;
  logic       o_sda;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       sda_bus;

  assign sda_bus = m_sda & o_sda;

  always #5 clk = ~clk;

  sccb_slave dut (
    .i_clk(clk), .i_rst(rst), .i_scl(scl), .i_sda(sda_bus),
    .o_sda(o_sda), .o_wr_valid(wr_valid), .o_wr_addr(wr_addr),
    .o_wr_data(wr_data), .o_busy(busy)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: register array, pointer, expected strobes.
  logic [7:0]  mem_m [256];
  logic [7:0]  ptr_m = 8'h00;
  logic [15:0] exp_q [$];
  logic [15:0] obs_q [$];
  logic [7:0]  wbuf [$];
  int          long_pulses = 0;
  int          ack_held = 0;
  logic        prev_valid = 1'b0;

  logic ack_g;
  int   vlat_g, alat_g, rlat_g;

  function automatic logic [7:0] model_rd(input logic [7:0] p);
    if (p == 8'h0A) return 8'h76;
    if (p == 8'h0B) return 8'h73;
    return mem_m[p];
  endfunction

  // Strobe capture on the falling clock edge.
  always @(negedge clk) begin
    if (wr_valid) obs_q.push_back({wr_addr, wr_data});
    if (wr_valid && prev_valid) long_pulses++;
    prev_valid = wr_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start;
    m_sda = 1'b1; tick(5);
    scl = 1'b1;   tick(10);
    m_sda = 1'b0; tick(10);
    scl = 1'b0;   tick(5);
  endtask

  task automatic bus_stop;
    m_sda = 1'b0; tick(5);
    scl = 1'b1;   tick(10);
    m_sda = 1'b1; tick(10);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_sda = b[i]; tick(5);
      scl = 1'b1;   tick(10);
      scl = 1'b0;   tick(5);
    end
  endtask

  // Full byte plus ACK bit; records strobe, ACK-assert and ACK-release latencies.
  task automatic write_byte(input logic [7:0] b);
    send_bits(b, 7);
    m_sda = b[0]; tick(5);
    scl = 1'b1;
    vlat_g = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (wr_valid && vlat_g < 0) vlat_g = c;
    end
    scl = 1'b0;
    alat_g = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) m_sda = 1'b1;
      if (o_sda == 1'b0 && alat_g < 0) alat_g = c;
    end
    scl = 1'b1; tick(5);
    ack_g = sda_bus; tick(5);
    scl = 1'b0;
    rlat_g = -1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (o_sda == 1'b1 && rlat_g < 0) rlat_g = c;
    end
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack_bit);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(5);
      scl = 1'b1; tick(5);
      b[i] = sda_bus; tick(5);
      scl = 1'b0; tick(5);
    end
    m_sda = ack_bit; tick(5);
    scl = 1'b1; tick(5);
    if (o_sda !== 1'b1) ack_held++;
    tick(5);
    scl = 1'b0; tick(2);
    m_sda = 1'b1; tick(3);
  endtask

  task automatic check_strobes(input string name);
    tests++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL %s strobe count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL %s strobe %0d: got %h expected %h", name, i, obs_q[i], exp_q[i]);
        end
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_ack(input string name);
    tests++;
    if (ack_g !== 1'b0) begin
      fails++;
      $display("FAIL %s ack: got %b expected 0", name, ack_g);
    end
  endtask

  // Sub-address then the bytes in wbuf; updates the model.
  task automatic do_write(input logic [7:0] sub);
    bus_start;
    write_byte(8'h42); check_ack("wr devaddr");
    write_byte(sub);   check_ack("wr subaddr");
    ptr_m = sub;
    foreach (wbuf[i]) begin
      write_byte(wbuf[i]); check_ack("wr data");
      exp_q.push_back({ptr_m, wbuf[i]});
      if (ptr_m != 8'h0A && ptr_m != 8'h0B) mem_m[ptr_m] = wbuf[i];
      ptr_m = ptr_m + 8'd1;
    end
    bus_stop;
    check_strobes("write");
    wbuf.delete();
  endtask

  task automatic do_read(input int n);
    logic [7:0] got;
    logic [7:0] expv;
    bus_start;
    write_byte(8'h43); check_ack("rd devaddr");
    for (int i = 0; i < n; i++) begin
      read_byte(got, (i == n - 1));
      expv = model_rd(ptr_m);
      tests++;
      if (got !== expv) begin
        fails++;
        $display("FAIL read byte %0d at ptr %h: got %h expected %h", i, ptr_m, got, expv);
      end
      if (i != n - 1) ptr_m = ptr_m + 8'd1;
    end
    bus_stop;
    check_strobes("read");
  endtask

  task automatic check_rst_outputs(input string name);
    tests++;
    if ({o_sda, wr_valid, wr_addr, wr_data, busy} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL %s outputs: got sda=%b v=%b a=%h d=%h busy=%b expected 1 0 00 00 0",
               name, o_sda, wr_valid, wr_addr, wr_data, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; scl = 1'b1; m_sda = 1'b1;
    tick(3);
    check_rst_outputs("reset");
    rst = 1'b0;
    tick(5);
    check_rst_outputs("post reset idle");
  endtask

  task automatic test_write;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL busy before start: got %b expected 0", busy); end
    bus_start;
    write_byte(8'h42); check_ack("write dev");
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy after match: got %b expected 1", busy); end
    tests++;
    if (alat_g !== 3) begin fails++; $display("FAIL ack assert latency: got %0d expected 3", alat_g); end
    tests++;
    if (rlat_g !== 3) begin fails++; $display("FAIL ack release latency: got %0d expected 3", rlat_g); end
    write_byte(8'h12); check_ack("write sub");
    tests++;
    if (vlat_g !== -1) begin fails++; $display("FAIL strobe on subaddr: got %0d expected none", vlat_g); end
    write_byte(8'h80); check_ack("write data");
    tests++;
    if (vlat_g !== 3) begin fails++; $display("FAIL strobe latency: got %0d expected 3", vlat_g); end
    exp_q.push_back({8'h12, 8'h80});
    mem_m[8'h12] = 8'h80;
    ptr_m = 8'h13;
    bus_stop;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL busy after stop: got %b expected 0", busy); end
    check_strobes("write 12");
  endtask

  task automatic test_readback;
    do_write(8'h12);
    do_read(1);
  endtask

  task automatic test_mismatch;
    bus_start;
    write_byte(8'h60);
    tests++;
    if (ack_g !== 1'b1 || alat_g !== -1) begin
      fails++; $display("FAIL mismatch nack: got ack=%b lat=%0d expected 1 none", ack_g, alat_g);
    end
    write_byte(8'h12);
    tests++;
    if (ack_g !== 1'b1) begin fails++; $display("FAIL ignored byte ack: got %b expected 1", ack_g); end
    bus_stop;
    check_strobes("mismatch");
    wbuf.push_back(8'h9C);
    do_write(8'h20);
    do_write(8'h20);
    do_read(1);
  endtask

  task automatic test_pid;
    do_write(8'h0A);
    do_read(2);
    wbuf.push_back(8'h55);
    do_write(8'h0A);
    do_write(8'h0A);
    do_read(1);
    tests++;
    if (ack_held !== 0) begin fails++; $display("FAIL sda held in master ack: got %0d expected 0", ack_held); end
  endtask

  task automatic test_wrap;
    wbuf.push_back(8'h11); wbuf.push_back(8'h22); wbuf.push_back(8'h33);
    do_write(8'hFE);
    do_write(8'hFE);
    do_read(3);
  endtask

  task automatic test_disruption;
    bus_start;
    write_byte(8'h42); check_ack("disr dev");
    write_byte(8'h30); check_ack("disr sub");
    send_bits(8'hC3, 4);
    bus_start;
    write_byte(8'h42); check_ack("restart dev");
    write_byte(8'h31); check_ack("restart sub");
    send_bits(8'hAB, 4);
    rst = 1'b1;
    tick(1);
    check_rst_outputs("mid-byte reset");
    rst = 1'b0;
    ptr_m = 8'h00;
    send_bits(8'hB0, 4);
    bus_stop;
    check_strobes("disruption");
    do_read(1);
    wbuf.push_back(8'h5A);
    do_write(8'h30);
    do_write(8'h30);
    do_read(1);
  endtask

  task automatic test_random;
    logic [7:0] sub;
    int n;
    for (int it = 0; it < 12; it++) begin
      sub = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) wbuf.push_back(8'($urandom));
      do_write(sub);
      do_write(sub);
      do_read(n);
    end
    tests++;
    if (long_pulses !== 0) begin fails++; $display("FAIL strobe width: got %0d long pulses expected 0", long_pulses); end
  endtask

  initial begin
    foreach (mem_m[i]) mem_m[i] = 8'h00;
    test_reset;
    test_write;
    test_readback;
    test_mismatch;
    test_pid;
    test_wrap;
    test_disruption;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
